// File: rtl/mac_pkg.sv
// Shared FSM state type and default widths for the mac window capture slice.
// Pure declarations: no latency, no flow control.
package mac_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/mac_window_capture_if.sv
// Result stream bundle (vld/rdy/dat) between the result buffer and its consumer.
// A beat transfers when vld && rdy; the master holds dat/vld while rdy is low.
interface mac_window_capture_if #(
  parameter int W = 16
);

  logic         vld;
  logic         rdy;
  logic [W-1:0] dat;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);

endinterface

// File: rtl/mac_result_fifo.sv
// Generic shift-style result FIFO of DEPTH entries, head at mem_q[0]; push visible next cycle.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged.
module mac_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push_vld,
  input  logic [W-1:0]                push_dat,
  output logic                        drop,
  mac_window_capture_if.master        out_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop;
  logic             accept;

  assign out_if.vld = (cnt_q != '0);
  assign out_if.dat = mem_q[0];

  always_comb begin
    pop    = (cnt_q != '0) && out_if.rdy;
    // A full FIFO still accepts when the head leaves in the same cycle.
    accept = push_vld && ((cnt_q != CNT_W'(DEPTH)) || pop);
    drop   = push_vld && !accept;
    wr_idx = cnt_q - CNT_W'(pop);
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      cnt_d = cnt_d - CNT_W'(1);
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          mem_d[i] = push_dat;
        end
      end
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mac_window_capture.sv
// Captures (end - base) of the mac accumulator over len updates; result valid 1 cycle after the final cycle.
// Backpressure via out_ready into a 1-entry buffer (2 with MAC_CAPTURE_FIFO2_EN); full-buffer drops set sticky overflow.
module mac_window_capture
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             overflow
);

`ifdef MAC_CAPTURE_FIFO2_EN
  localparam int FIFO_DEPTH = 2;
`else
  localparam int FIFO_DEPTH = 1;
`endif

  state_t           state_q, state_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W:0]   len_ld;
  logic [ACC_W-1:0] base_q, base_d;
  logic             ovf_q, ovf_d;
  logic             push_vld;
  logic [ACC_W-1:0] push_dat;
  logic             drop;

  mac_window_capture_if #(.W(ACC_W)) res_if ();

  always_comb begin
    // len of zero encodes the full 2^LEN_W window, hence the extra counter bit.
    len_ld   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    push_vld = 1'b0;
    push_dat = acc_in - base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = acc_in;
          cnt_d   = len_ld;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (cnt_q == (LEN_W + 1)'(1)) begin
          push_vld = 1'b1;
          if (start) begin
            base_d = acc_in;
            cnt_d  = len_ld;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - (LEN_W + 1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = (ovf_q && !clr_ovf) || drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
    end
  end

  mac_result_fifo #(
    .W     (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .drop     (drop),
    .out_if   (res_if)
  );

  assign res_if.rdy = out_ready;
  assign out_valid  = res_if.vld;
  assign out_data   = res_if.dat;
  assign busy       = (state_q == COUNT);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_window_capture.sv
// Bench for mac_window_capture: fixed vector table, directed corner sequences and random traffic vs a window/queue model.
// Result buffer depth follows MAC_CAPTURE_FIFO2_EN exactly like the design.
module tb_mac_window_capture;
  import mac_pkg::*;

  localparam int ACC_W = ACC_W_DEF;
  localparam int LEN_W = LEN_W_DEF;
`ifdef MAC_CAPTURE_FIFO2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [ACC_W-1:0] acc_in;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             out_ready;
  logic             clr_ovf;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic             overflow;

  always #5 clk = ~clk;

  mac_window_capture_if #(.W(ACC_W)) mon_if ();
  assign mon_if.vld = out_valid;
  assign mon_if.dat = out_data;
  assign mon_if.rdy = out_ready;

  mac_window_capture #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_in    (acc_in),
    .start     (start),
    .len       (len),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Model: an open window is a (base value, closing cycle) pair; the buffer is a bounded queue.
  int               cyc;
  bit               m_open;
  logic [ACC_W-1:0] m_base;
  int               m_end;
  logic [ACC_W-1:0] m_q[$];
  bit               m_ovf;
  int               n_checks;
  int               n_fail;

  typedef struct {
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] acc;
    logic             rdy;
    logic             clr;
    logic             e_vld;
    logic [ACC_W-1:0] e_dat;
    logic             e_busy;
    logic             e_ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [LEN_W-1:0] l, input logic [ACC_W-1:0] a,
                       input logic r, input logic c);
    start = s; len = l; acc_in = a; out_ready = r; clr_ovf = c;
  endtask

  task automatic model_edge();
    bit               pop;
    bit               push;
    bit               dropped;
    logic [ACC_W-1:0] val;
    pop  = (m_q.size() > 0) && out_ready;
    push = m_open && (cyc == m_end);
    val  = acc_in - m_base;
    if (!m_open || cyc == m_end) begin
      if (start) begin
        m_open = 1'b1;
        m_base = acc_in;
        m_end  = cyc + ((len == '0) ? (1 << LEN_W) : int'(len));
      end else begin
        m_open = 1'b0;
      end
    end
    if (pop) void'(m_q.pop_front());
    dropped = 1'b0;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(val);
      else dropped = 1'b1;
    end
    if (clr_ovf) m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    cyc++;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, 32'(mon_if.vld), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check({tag, ".data"}, 32'(mon_if.dat), 32'(m_q[0]));
    check({tag, ".busy"}, 32'(busy), 32'(m_open));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_open  = 1'b0;
    m_base  = '0;
    m_ovf   = 1'b0;
    m_q.delete();
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data", 32'(out_data), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].start, tbl[i].len, tbl[i].acc, tbl[i].rdy, tbl[i].clr);
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.vec_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) check($sformatf("tbl%0d.vec_data", i), 32'(out_data), 32'(tbl[i].e_dat));
      check($sformatf("tbl%0d.vec_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d.vec_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [ACC_W-1:0] a;
    int               nres;

    // single window (100 -> 200 over 4 updates) then a wrapping 1-update window
    tbl[0] = '{1'b1, 8'd4, 16'd100,    1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 16'd110,    1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 16'd130,    1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 16'd160,    1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 16'd200,    1'b0, 1'b0, 1'b1, 16'd100,  1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 16'd200,    1'b1, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'd1, 16'hFFF0,   1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 16'h0010,   1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd0, 16'h0010,   1'b1, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0};

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_end    = 0;
    reset_n  = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    do_reset();

    run_table(0, 8);

    // back-to-back windows: start held, len=2, +5 per cycle
    a = 16'd1000;
    nres = 0;
    drive(1'b1, 8'd2, a, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step("b2b");
      check("b2b.busy_held", 32'(busy), 32'd1);
      if (out_valid) begin
        check("b2b.sum", 32'(out_data), 32'd10);
        nres++;
      end
      a = a + 16'd5;
      acc_in = a;
    end
    check("b2b.results", 32'(nres), 32'd5);
    start = 1'b0;
    repeat (4) step("b2b_tail");

    // overflow: three 1-update windows with the consumer stalled
    drive(1'b1, 8'd1, 16'd50, 1'b0, 1'b0);
    step("ovf_open");
    for (int w = 1; w <= 3; w++) begin
      if (w == 3) start = 1'b0;
      acc_in = acc_in + 16'(w * 7);
      step("ovf");
      check($sformatf("ovf.after_window%0d", w), 32'(overflow), 32'(w > DEPTH));
    end
    clr_ovf = 1'b1;
    step("ovf_clr");
    check("ovf.cleared", 32'(overflow), 32'd0);
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    repeat (4) step("ovf_drain");

    // full buffer with pop and push in the same cycle
    drive(1'b1, 8'd1, 16'd300, 1'b0, 1'b0);
    step("full_open");
    for (int k = 1; k <= DEPTH; k++) begin
      acc_in = acc_in + 16'(k * 3 + 1);
      step("full_fill");
    end
    acc_in    = acc_in + 16'd9;
    start     = 1'b0;
    out_ready = 1'b1;
    step("full_pushpop");
    check("full_pushpop.no_ovf", 32'(overflow), 32'd0);
    repeat (4) step("full_drain");

    // reset in the middle of a 4-update window, after one count cycle
    drive(1'b1, 8'd4, 16'd7, 1'b1, 1'b0);
    step("mid_open");
    start  = 1'b0;
    acc_in = 16'd20;
    step("mid_count");
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step("post_rst");
      check("post_rst.no_result", 32'(out_valid), 32'd0);
    end
    run_table(0, 5);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 40) == 0) ? '0 : LEN_W'($urandom_range(1, 6));
      acc_in    = ACC_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
